// File: rtl/sram_rd_stream.sv
// Streams len consecutive SRAM words (address wraps modulo SIZE) into a valid/ready output.
// A credit check on outstanding reads plus FIFO occupancy lets the stream stall without losing returns.

module sram_rd_stream_fifo #(
  parameter int DATA_WD = 8,
  parameter int DEPTH   = 4,
  localparam int PTR_WD = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_WD = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               push,
  input  logic [DATA_WD-1:0] push_dat,
  input  logic               pop,
  output logic [DATA_WD-1:0] head,
  output logic               empty,
  output logic [CNT_WD-1:0]  count
);

  logic [DATA_WD-1:0] mem [DEPTH];
  logic [PTR_WD-1:0]  wr_ptr;
  logic [PTR_WD-1:0]  rd_ptr;

  function automatic logic [PTR_WD-1:0] ptr_inc(input logic [PTR_WD-1:0] p);
    return (p == PTR_WD'(DEPTH - 1)) ? '0 : p + PTR_WD'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + CNT_WD'(1);
      else if (pop && !push) count <= count - CNT_WD'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  assign empty = (count == '0);
  // Gate the head so the stream data reads 0 whenever nothing is valid, including after reset.
  assign head  = empty ? '0 : mem[rd_ptr];

endmodule

module sram_rd_stream #(
  parameter int KNOB_REGOUT = 0,
  parameter int SIZE        = 8,
  parameter int DATA_WD     = 16,
  parameter int FIFO_DEPTH  = 4,
  localparam int SIZE_WD    = $clog2(SIZE)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start_i,
  input  logic [SIZE_WD-1:0] bas_adr_i,
  input  logic [SIZE_WD:0]   len_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [SIZE_WD-1:0] sram_adr_o,
  output logic               sram_rd_val_o,
  input  logic               sram_rd_val_i,
  input  logic [DATA_WD-1:0] sram_rd_dat_i,
  output logic               dat_val_o,
  input  logic               dat_rdy_i,
  output logic [DATA_WD-1:0] dat_dat_o
);

  localparam int CNT_WD = $clog2(FIFO_DEPTH + 1);
  localparam int SUM_WD = CNT_WD + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN
  } state_t;

  state_t             state;
  logic [SIZE_WD-1:0] adr;
  logic [SIZE_WD:0]   iss_rem;
  logic [SIZE_WD:0]   acc_rem;
  logic [CNT_WD-1:0]  outstanding;
  logic [CNT_WD-1:0]  fifo_cnt;
  logic [SUM_WD-1:0]  credit_sum;
  logic               fifo_empty;
  logic               pop;
  logic               ret;
  logic               issue;
  logic               zero_done;

  assign pop = dat_val_o & dat_rdy_i;
  // A return with nothing outstanding belongs to a read issued before reset and is discarded.
  assign ret = sram_rd_val_i & (outstanding != '0);

  // A return moves one credit from outstanding into the FIFO, so only a pop changes the sum.
  assign credit_sum = SUM_WD'(outstanding) + SUM_WD'(fifo_cnt) - SUM_WD'(pop);
  assign issue      = (state == S_ISSUE) && (credit_sum < SUM_WD'(FIFO_DEPTH));

  assign dat_val_o = !fifo_empty;
  assign busy_o    = (state != S_IDLE);
  assign done_o    = zero_done | ((state == S_DRAIN) & pop & (acc_rem == (SIZE_WD+1)'(1)));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state         <= S_IDLE;
      adr           <= '0;
      iss_rem       <= '0;
      acc_rem       <= '0;
      outstanding   <= '0;
      sram_rd_val_o <= 1'b0;
      sram_adr_o    <= '0;
      zero_done     <= 1'b0;
    end else begin
      sram_rd_val_o <= issue;
      zero_done     <= 1'b0;

      if (issue) begin
        sram_adr_o <= adr;
        adr        <= (adr == SIZE_WD'(SIZE - 1)) ? '0 : adr + SIZE_WD'(1);
        iss_rem    <= iss_rem - (SIZE_WD+1)'(1);
      end

      if (issue && !ret)      outstanding <= outstanding + CNT_WD'(1);
      else if (!issue && ret) outstanding <= outstanding - CNT_WD'(1);

      if (pop) acc_rem <= acc_rem - (SIZE_WD+1)'(1);

      case (state)
        S_IDLE: begin
          if (start_i) begin
            if (len_i == '0) begin
              zero_done <= 1'b1;
            end else begin
              state   <= S_ISSUE;
              adr     <= bas_adr_i;
              iss_rem <= len_i;
              acc_rem <= len_i;
            end
          end
        end
        S_ISSUE: begin
          if (issue && (iss_rem == (SIZE_WD+1)'(1))) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (pop && (acc_rem == (SIZE_WD+1)'(1))) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  sram_rd_stream_fifo #(
    .DATA_WD (DATA_WD),
    .DEPTH   (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rstn     (rstn),
    .push     (ret),
    .push_dat (sram_rd_dat_i),
    .pop      (pop),
    .head     (dat_dat_o),
    .empty    (fifo_empty),
    .count    (fifo_cnt)
  );

endmodule
